// File: rtl/vc_pkg.sv
// Shared types and helpers for the NoC VC flag tracker.
package vc_pkg;

    localparam int NUM_VC      = 8;
    localparam int CREDIT_W    = 3;
    localparam int MAX_CREDITS = 4;
    localparam int VC_IW       = $clog2(NUM_VC);

    typedef enum logic [1:0] {
        VC_IDLE  = 2'd0,
        VC_ALLOC = 2'd1,
        VC_DRAIN = 2'd2
    } vc_state_e;

    function automatic logic is_onehot(input logic [NUM_VC-1:0] v);
        return (v != '0) && ((v & (v - NUM_VC'(1))) == '0);
    endfunction

    // Out-of-range indices decode to all zeros.
    function automatic logic [NUM_VC-1:0] idx_to_onehot(
        input logic [VC_IW-1:0] idx
    );
        logic [NUM_VC-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            oh[i] = (idx == VC_IW'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/vc_slot.sv
// One virtual channel: IDLE/ALLOC/DRAIN FSM plus saturating credit counter.
module vc_slot
    import vc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic alloc_hit_i,
    input  logic send_hit_i,
    input  logic send_tail_i,
    input  logic credit_hit_i,
    output logic is_free_o,
    output logic is_alloc_o,
    output logic has_credit_o,
    output logic sat_o
);

    localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(MAX_CREDITS);

    vc_state_e           state_q;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                free_q, avail_q;
    logic                full;

    assign full = (credit_q == CMAX);

    // Send and return in the same cycle cancel out.
    always_comb begin
        credit_d = credit_q;
        if (credit_hit_i && !send_hit_i && !full) begin
            credit_d = credit_q + CREDIT_W'(1);
        end else if (send_hit_i && !credit_hit_i) begin
            credit_d = credit_q - CREDIT_W'(1);
        end
    end

    assign sat_o = credit_hit_i && !send_hit_i && full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= VC_IDLE;
            free_q   <= 1'b1;
            credit_q <= CMAX;
            avail_q  <= 1'b1;
        end else begin
            credit_q <= credit_d;
            avail_q  <= (credit_d != '0);
            unique case (state_q)
                VC_IDLE: begin
                    if (alloc_hit_i) begin
                        state_q <= VC_ALLOC;
                        free_q  <= 1'b0;
                    end
                end
                VC_ALLOC: begin
                    if (send_hit_i && send_tail_i) begin
                        state_q <= VC_DRAIN;
                    end
                end
                VC_DRAIN: begin
                    if (credit_d == CMAX) begin
                        state_q <= VC_IDLE;
                        free_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= VC_IDLE;
                    free_q  <= 1'b1;
                end
            endcase
        end
    end

    assign is_free_o    = free_q;
    assign is_alloc_o   = (state_q == VC_ALLOC);
    assign has_credit_o = avail_q;

endmodule

// File: rtl/vc_flag_tracker.sv
// Per-VC occupancy/credit tracker producing free flags for the VC selector.
// Define VC_TRACKER_ERR_CHECK_EN to enable the sticky protocol error flag.
module vc_flag_tracker
    import vc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [NUM_VC-1:0] free_flags,
    input  logic              alloc_valid,
    input  logic [NUM_VC-1:0] alloc_onehot,
    output logic              alloc_ready,
    input  logic              send_valid,
    input  logic [NUM_VC-1:0] send_onehot,
    input  logic              send_tail,
    output logic              send_ready,
    input  logic              credit_valid,
    input  logic [VC_IW-1:0]  credit_vc,
    output logic [NUM_VC-1:0] credit_avail,
    output logic              err
);

    logic [NUM_VC-1:0] alloc_hit, send_hit, credit_hit;
    logic [NUM_VC-1:0] is_alloc, sat;
    logic [NUM_VC-1:0] credit_oh;

    assign credit_oh = idx_to_onehot(credit_vc);

    assign alloc_ready = is_onehot(alloc_onehot)
                       && |(alloc_onehot & free_flags);
    assign send_ready  = is_onehot(send_onehot)
                       && |(send_onehot & is_alloc & credit_avail);

    assign alloc_hit  = (alloc_valid && alloc_ready) ? alloc_onehot : '0;
    assign send_hit   = (send_valid && send_ready) ? send_onehot : '0;
    assign credit_hit = credit_valid ? credit_oh : '0;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_slot
        vc_slot u_slot (
            .clk          (clk),
            .rst_n        (rst_n),
            .alloc_hit_i  (alloc_hit[i]),
            .send_hit_i   (send_hit[i]),
            .send_tail_i  (send_tail),
            .credit_hit_i (credit_hit[i]),
            .is_free_o    (free_flags[i]),
            .is_alloc_o   (is_alloc[i]),
            .has_credit_o (credit_avail[i]),
            .sat_o        (sat[i])
        );
    end

`ifdef VC_TRACKER_ERR_CHECK_EN
    logic err_q, err_ev;

    assign err_ev = (alloc_valid && !is_onehot(alloc_onehot))
                 || (send_valid && !send_ready)
                 || (credit_valid && (credit_oh == '0))
                 || (|sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_ev;
        end
    end

    assign err = err_q;
`else
    logic unused_sat;
    assign unused_sat = ^sat;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_vc_flag_tracker.sv
// Table-driven bench for vc_flag_tracker with a registered-output scoreboard.
module tb_vc_flag_tracker;

`ifdef VC_TRACKER_ERR_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif
    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] free_flags, credit_avail;
    logic       alloc_valid = 1'b0, send_valid = 1'b0;
    logic [7:0] alloc_onehot = '0, send_onehot = '0;
    logic       send_tail = 1'b0, credit_valid = 1'b0;
    logic [2:0] credit_vc = '0;
    logic       alloc_ready, send_ready, err;

    always #5 clk = ~clk;

    vc_flag_tracker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .free_flags   (free_flags),
        .alloc_valid  (alloc_valid),
        .alloc_onehot (alloc_onehot),
        .alloc_ready  (alloc_ready),
        .send_valid   (send_valid),
        .send_onehot  (send_onehot),
        .send_tail    (send_tail),
        .send_ready   (send_ready),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_avail (credit_avail),
        .err          (err)
    );

    typedef struct {
        logic       av;
        logic [7:0] aoh;
        logic       sv;
        logic [7:0] soh;
        logic       st;
        logic       cv;
        logic [2:0] cvc;
        logic       bad;
        logic       ear;
        logic       esr;
        logic [7:0] eff;
        logic [7:0] eca;
    } vec_t;

    typedef struct {
        logic [7:0] ff;
        logic [7:0] ca;
        logic       er;
        string      nm;
    } exp_t;

    exp_t  sb[$];
    vec_t  tv[22];
    int    checks = 0;
    int    errors = 0;
    logic  err_exp = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alloc_valid  = v.av;
        alloc_onehot = v.aoh;
        send_valid   = v.sv;
        send_onehot  = v.soh;
        send_tail    = v.st;
        credit_valid = v.cv;
        credit_vc    = v.cvc;
    endtask

    task automatic step(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        drive(v);
        #1;
        chk({nm, ".alloc_ready"}, 8'(alloc_ready), 8'(v.ear));
        chk({nm, ".send_ready"}, 8'(send_ready), 8'(v.esr));
        if (v.bad) err_exp = ERR_ON;
        e = '{v.eff, v.eca, err_exp, nm};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s.scoreboard: got empty expected entry", nm);
        end else begin
            e = sb.pop_front();
            chk({e.nm, ".free_flags"}, free_flags, e.ff);
            chk({e.nm, ".credit_avail"}, credit_avail, e.ca);
            chk({e.nm, ".err"}, 8'(err), 8'(e.er));
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".free_flags"}, free_flags, 8'hFF);
        chk({nm, ".credit_avail"}, credit_avail, 8'hFF);
        chk({nm, ".err"}, 8'(err), 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t idle;
        idle = '{F, 8'h00, F, 8'h00, F, F, 3'd0, F, F, F, 8'hFF, 8'hFF};
        //         av aoh    sv soh    st cv cvc  bad ar sr ff     ca
        tv[0]  = '{T, 8'h01, F, 8'h00, F, F, 3'd0, F, T, F, 8'hFE, 8'hFF};
        tv[1]  = '{T, 8'h01, F, 8'h00, F, F, 3'd0, F, F, F, 8'hFE, 8'hFF};
        tv[2]  = '{F, 8'h00, T, 8'h01, F, F, 3'd0, F, F, T, 8'hFE, 8'hFF};
        tv[3]  = '{F, 8'h00, T, 8'h01, F, F, 3'd0, F, F, T, 8'hFE, 8'hFF};
        tv[4]  = '{F, 8'h00, T, 8'h01, F, F, 3'd0, F, F, T, 8'hFE, 8'hFF};
        tv[5]  = '{F, 8'h00, T, 8'h01, T, F, 3'd0, F, F, T, 8'hFE, 8'hFE};
        tv[6]  = '{F, 8'h00, T, 8'h01, F, F, 3'd0, T, F, F, 8'hFE, 8'hFE};
        tv[7]  = '{F, 8'h00, F, 8'h00, F, T, 3'd0, F, F, F, 8'hFE, 8'hFF};
        tv[8]  = '{F, 8'h00, F, 8'h00, F, T, 3'd0, F, F, F, 8'hFE, 8'hFF};
        tv[9]  = '{F, 8'h00, F, 8'h00, F, T, 3'd0, F, F, F, 8'hFE, 8'hFF};
        tv[10] = '{F, 8'h00, F, 8'h00, F, T, 3'd0, F, F, F, 8'hFF, 8'hFF};
        tv[11] = '{F, 8'h00, F, 8'h00, F, T, 3'd0, T, F, F, 8'hFF, 8'hFF};
        tv[12] = '{T, 8'h04, F, 8'h00, F, F, 3'd0, F, T, F, 8'hFB, 8'hFF};
        tv[13] = '{F, 8'h00, T, 8'h04, F, F, 3'd0, F, F, T, 8'hFB, 8'hFF};
        tv[14] = '{F, 8'h00, T, 8'h04, F, F, 3'd0, F, F, T, 8'hFB, 8'hFF};
        tv[15] = '{T, 8'h08, T, 8'h04, F, T, 3'd2, F, T, T, 8'hF3, 8'hFF};
        tv[16] = '{F, 8'h00, T, 8'h04, F, F, 3'd0, F, F, T, 8'hF3, 8'hFF};
        tv[17] = '{F, 8'h00, T, 8'h04, F, F, 3'd0, F, F, T, 8'hF3, 8'hFB};
        tv[18] = '{F, 8'h00, T, 8'h04, F, F, 3'd0, T, F, F, 8'hF3, 8'hFB};
        tv[19] = '{F, 8'h00, T, 8'h02, F, F, 3'd0, T, F, F, 8'hF3, 8'hFB};
        tv[20] = '{T, 8'h03, F, 8'h00, F, F, 3'd0, T, F, F, 8'hF3, 8'hFB};
        tv[21] = '{T, 8'h02, T, 8'h08, T, T, 3'd2, F, T, T, 8'hF1, 8'hFF};

        #3 rst_n = 1'b0;
        #1 chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk_reset("por_release");

        for (int i = 0; i < 22; i++) begin
            step(tv[i], $sformatf("v%0d", i));
        end

        // Reset with traffic still applied and VCs mid-packet.
        @(negedge clk);
        drive(tv[21]);
        rst_n = 1'b0;
        #1 chk_reset("rst_low");
        @(posedge clk);
        #1 chk_reset("rst_held");
        @(negedge clk);
        drive(idle);
        rst_n   = 1'b1;
        err_exp = 1'b0;
        @(posedge clk);
        #1 chk_reset("rst_after");

        step('{T, 8'h80, F, 8'h00, F, F, 3'd0, F, T, F, 8'h7F, 8'hFF},
             "post_alloc7");
        step('{T, 8'h00, F, 8'h00, F, F, 3'd0, T, F, F, 8'h7F, 8'hFF},
             "post_zero_alloc");
        step('{F, 8'h00, F, 8'h00, F, T, 3'd7, T, F, F, 8'h7F, 8'hFF},
             "post_credit_sat7");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
